shift_add_mult_ctrl: RTL and testbench
======================================

Name: shift_add_mult_ctrl

Overview:
- Multi-cycle unsigned multiplier controller: sequences a single N-bit ripple-carry adder through a shift-and-add algorithm to form a 2N-bit product.
- Lets the lab datapath multiply using only the existing adder style, with no array multiplier.
- Sits between a requester (switch/button front end or testbench) and display logic.
- Uses a start/ready/done handshake.

Parameters:
- N, 4, operand width in bits; product width is 2N; N >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- a  input  N  multiplicand; captured on accepted start.
- b  input  N  multiplier; captured on accepted start.
- ready  output  1  block can accept start this cycle.
- busy  output  1  iteration in progress.
- done  output  1  one-cycle pulse; product valid.
- product  output  2N  result register; holds until the next accepted start completes.

Behaviour:
- Single clock (clk); reset is synchronous and active-high. reset=1 at a rising edge overrides everything, including mid-operation.
- Reset values: state=IDLE, product=0, done=0, busy=0, ready=1, counter=0, internal registers=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - start=1 -> capture mcand<=a; acc<={N'b0, b}; cnt<=0; go to CALC.
- CALC:
  - busy=1, ready=0. start is ignored; a/b changes are ignored.
  - Each cycle: the adder sums acc[2N-1:N] + (acc[0] ? mcand : 0) with c_in=0, giving sum s and carry c.
  - Shift right: acc <= {c, s, acc[N-1:1]}; cnt <= cnt+1.
  - After the N-th iteration (cnt==N-1 at the edge): product <= next acc value; go to DONE.
- DONE:
  - done=1 for exactly this cycle; ready=1.
  - start=1 -> accepted identically to IDLE (back-to-back). done still pulses this cycle; product is unchanged until the new result.
  - start=0 -> IDLE.
- Latency: start accepted at edge E0; done high in the cycle after edge E0+N, i.e. N+1 cycles from start acceptance. Throughput is one result per N+1 cycles.
- Arithmetic:
  - Unsigned only. The adder carry-out becomes acc MSB, so no overflow is possible: max (2^N-1)^2 < 2^(2N).
- Boundaries:
  - a=0 or b=0 yields 0; still takes the full N cycles (no early exit).
  - start held high continuously produces consecutive multiplications, each with its own done pulse.
  - Reset during CALC aborts: product=0, and no done pulse.
- Counter width: CNT_W = $clog2(N); it must not wrap before N-1 is reached.
- All outputs are registered or decoded from the state register; no combinational path from start to done.

Decomposition:
- Package mult_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t.
  - function/constant for CNT_W.
- Sub-module ripple_adder #(N): N-bit chained full-adder slices.
  - Ports a, b, c_in, s[N-1:0], c_out.
  - The controller instantiates exactly one.

Test Plan:
- reset held 2 cycles, then released -> product=0, ready=1, busy=0, done=0; no activity without start.
- a=9, b=6, start 1 cycle -> busy for 4 cycles; done pulses in the 5th cycle after acceptance; product=54 (0x36) and holds after done.
- a=15, b=15 -> product=225 (0xE1), carry path exercised. a=0, b=13 -> product=0 with the same 5-cycle latency.
- start held high with a=3,b=5 then a=7,b=7 presented at each DONE -> done pulses every 5 cycles; products 15, then 49; no lost or duplicate results.
- a=12,b=11 accepted; at cycle 2, change a/b to 1,1 and pulse start -> ignored; product=132.
- Reset asserted at CALC cycle 2 -> next cycle IDLE, product=0, no done. A subsequent a=2,b=3 gives product=6.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier controller.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  // Iteration counter width; must reach N-1 without wrapping.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder built from chained full-adder slices.
module ripple_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  logic [N:0] carry;

  assign carry[0] = c_in;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign s[gi]        = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c_out = carry[N];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Multi-cycle unsigned multiplier: one N-bit adder reused over N shift-and-add
// iterations to build a 2N-bit product, with a start/ready/done handshake.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CNT_W = cnt_width(N);

  mult_state_t      state_reg, state_next;
  logic [N-1:0]     mcand_reg, mcand_next;
  logic [2*N-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2*N-1:0]   product_reg, product_next;

  logic [N-1:0]     add_b;
  logic [N-1:0]     sum_s;
  logic             sum_c;
  logic [2*N-1:0]   acc_shift;

  assign add_b = acc_reg[0] ? mcand_reg : '0;

  ripple_adder #(.N(N)) u_adder (
    .a     (acc_reg[2*N-1:N]),
    .b     (add_b),
    .c_in  (1'b0),
    .s     (sum_s),
    .c_out (sum_c)
  );

  // Adder carry-out lands in the MSB, so the shifted accumulator never overflows.
  assign acc_shift = {sum_c, sum_s, acc_reg[N-1:1]};

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          mcand_next = a;
          acc_next   = {{N{1'b0}}, b};
          cnt_next   = '0;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        acc_next = acc_shift;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(N - 1)) begin
          product_next = acc_shift;
          state_next   = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

  // Handshake outputs decode the state register only, so start never reaches done combinationally.
  assign ready   = (state_reg != CALC);
  assign busy    = (state_reg == CALC);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench: directed handshake scenarios plus random operands
// compared against plain a*b with an N+1 cycle latency expectation.
module tb_shift_add_mult_ctrl;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] product;

  int           n_checks = 0;
  int           n_fails  = 0;
  logic [W-1:0] held_product;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_done"}, {31'd0, done}, 1'b0);
    check({tag, "_busy_ready"}, {30'd0, busy, ready}, 2'b01);
    check({tag, "_product"}, {24'd0, product}, {24'd0, held_product});
  endtask

  // Waits (bounded) for ready, presents operands, and lets one edge accept them.
  task automatic accept(input int x, input int y, input bit hold_start);
    int guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    check("ready_before_start", {31'd0, ready}, 1);
    a     = x[N-1:0];
    b     = y[N-1:0];
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
  endtask

  // k0 = cycles elapsed since the accepting edge (1 right after accept).
  task automatic await_done(input string tag, input int exp_prod, input int k0);
    int k;
    logic [W-1:0] exp_w;
    k = k0;
    while (done !== 1'b1 && k <= N + 3) begin
      check({tag, "_busy"}, {30'd0, busy, ready}, 2'b10);
      check({tag, "_hold"}, {24'd0, product}, {24'd0, held_product});
      tick();
      k++;
    end
    exp_w = exp_prod[W-1:0];
    check({tag, "_done"}, {31'd0, done}, 1);
    check({tag, "_latency"}, k, N + 1);
    check({tag, "_product"}, {24'd0, product}, {24'd0, exp_w});
    check({tag, "_ready_at_done"}, {31'd0, ready}, 1);
    held_product = exp_w;
  endtask

  initial begin
    int x, y, x2, y2, gap;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    held_product = '0;
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");
    for (int i = 0; i < 3; i++) tick();
    check_idle("no_start");

    accept(9, 6, 1'b0);
    await_done("m9x6", 54, 1);
    tick();
    check_idle("m9x6_after");

    accept(15, 15, 1'b0);
    await_done("m15x15", 225, 1);
    tick();
    check_idle("m15x15_after");

    accept(0, 13, 1'b0);
    await_done("m0x13", 0, 1);
    tick();
    check_idle("m0x13_after");

    // start held high: second request presented while the first completes
    accept(3, 5, 1'b1);
    a = 4'd7;
    b = 4'd7;
    await_done("b2b_first", 15, 1);
    tick();
    start = 1'b0;
    await_done("b2b_second", 49, 1);
    tick();
    check_idle("b2b_after");

    // operand changes and a start pulse mid-calculation must be ignored
    accept(12, 11, 1'b0);
    tick();
    tick();
    a     = 4'd1;
    b     = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    await_done("ignore_mid", 132, 4);
    tick();
    check_idle("ignore_after");

    // reset during CALC aborts with no done pulse
    accept(9, 6, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    held_product = '0;
    check_idle("abort");
    for (int i = 0; i < N + 2; i++) begin
      check("abort_no_done", {31'd0, done}, 0);
      tick();
    end
    accept(2, 3, 1'b0);
    await_done("m2x3", 6, 1);
    tick();
    check_idle("m2x3_after");

    for (int t = 0; t < 20; t++) begin
      x   = int'($urandom_range(0, (1 << N) - 1));
      y   = int'($urandom_range(0, (1 << N) - 1));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
      accept(x, y, 1'b0);
      await_done("rand", x * y, 1);
      tick();
      check_idle("rand_after");
    end

    for (int t = 0; t < 6; t++) begin
      x  = int'($urandom_range(0, (1 << N) - 1));
      y  = int'($urandom_range(0, (1 << N) - 1));
      x2 = int'($urandom_range(0, (1 << N) - 1));
      y2 = int'($urandom_range(0, (1 << N) - 1));
      accept(x, y, 1'b1);
      await_done("rand_b2b_a", x * y, 1);
      a = x2[N-1:0];
      b = y2[N-1:0];
      tick();
      start = 1'b0;
      await_done("rand_b2b_b", x2 * y2, 1);
      tick();
      check_idle("rand_b2b_after");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
